// File: rtl/mc_controller_hs_if.sv
// ---------------------------------------------------------------------------
// mc_controller_hs_if
// Memory handshake bundle between the multicycle controller and its
// instruction/data memories.
//   imem_req      controller -> imem : instruction fetch request
//   imem_ready    imem -> controller : instruction word valid
//   dm_req        controller -> dmem : data access request
//   dm_wr         controller -> dmem : write enable, qualified by dm_req
//   word_byte_sel controller -> dmem : 1 = byte access (lb/sb)
//   dm_ready      dmem -> controller : data access complete
// ---------------------------------------------------------------------------
interface mc_controller_hs_if;
  logic imem_req;
  logic imem_ready;
  logic dm_req;
  logic dm_wr;
  logic word_byte_sel;
  logic dm_ready;

  modport master (
    output imem_req, dm_req, dm_wr, word_byte_sel,
    input  imem_ready, dm_ready
  );

  modport slave (
    input  imem_req, dm_req, dm_wr, word_byte_sel,
    output imem_ready, dm_ready
  );
endinterface

// File: rtl/mc_controller_hs.sv
// ---------------------------------------------------------------------------
// mc_controller_hs
// Multicycle MIPS control unit with ready/req memory handshakes, a memory
// wait timeout and a precise exception path (overflow, illegal, timeout).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   mem              memory handshake bundle (master side)
//   i_opcode/i_funct IR[31:26] / IR[5:0]
//   i_zero           ALU zero flag
//   i_overflow       ALU signed-overflow flag
//   o_pc_wr, o_npc_sel, o_ir_wr, o_gpr_wr          PC/IR/GPR control
//   o_alu_ctr, o_reg_dst, o_reg_from_sel           datapath selects
//   o_b_sel, o_ext_op                              ALU B operand / extender
//   o_epc_wr, o_cause_wr, o_exc_cause              exception registers
//   o_state                                        current state (debug)
// ---------------------------------------------------------------------------
module mc_controller_hs #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit EXC_EN      = 1'b1,
  parameter int CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  mc_controller_hs_if.master    mem,
  input  logic [5:0]            i_opcode,
  input  logic [5:0]            i_funct,
  input  logic                  i_zero,
  input  logic                  i_overflow,
  output logic                  o_pc_wr,
  output logic [2:0]            o_npc_sel,
  output logic                  o_ir_wr,
  output logic                  o_gpr_wr,
  output logic [2:0]            o_alu_ctr,
  output logic [1:0]            o_reg_dst,
  output logic [1:0]            o_reg_from_sel,
  output logic                  o_b_sel,
  output logic [1:0]            o_ext_op,
  output logic                  o_epc_wr,
  output logic                  o_cause_wr,
  output logic [1:0]            o_exc_cause,
  output logic [3:0]            o_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_EXC    = 4'd10
  } state_t;

  localparam logic [1:0] CAUSE_OVF = 2'b01;
  localparam logic [1:0] CAUSE_ILL = 2'b10;
  localparam logic [1:0] CAUSE_TMO = 2'b11;

  // Last counter value that may still be waited through; only meaningful
  // when the timeout is enabled.
  localparam logic [CNT_W-1:0] TMO_LAST =
    (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_t           r_state, w_state_next;
  logic [1:0]       r_cause, w_cause_next;
  logic [CNT_W-1:0] r_cnt;

  // ---------------- instruction decode ----------------
  logic w_rtype, w_addu, w_subu, w_slt, w_jr;
  logic w_addi, w_addiu, w_ori, w_lui;
  logic w_lw, w_sw, w_lb, w_sb, w_beq, w_bne, w_j, w_jal;
  logic w_load, w_store, w_alu_op, w_branch, w_jump;

  assign w_rtype  = (i_opcode == 6'h00);
  assign w_addu   = w_rtype && (i_funct == 6'h21);
  assign w_subu   = w_rtype && (i_funct == 6'h23);
  assign w_slt    = w_rtype && (i_funct == 6'h2a);
  assign w_jr     = w_rtype && (i_funct == 6'h08);
  assign w_addi   = (i_opcode == 6'h08);
  assign w_addiu  = (i_opcode == 6'h09);
  assign w_ori    = (i_opcode == 6'h0d);
  assign w_lui    = (i_opcode == 6'h0f);
  assign w_lw     = (i_opcode == 6'h23);
  assign w_sw     = (i_opcode == 6'h2b);
  assign w_lb     = (i_opcode == 6'h20);
  assign w_sb     = (i_opcode == 6'h28);
  assign w_beq    = (i_opcode == 6'h04);
  assign w_bne    = (i_opcode == 6'h05);
  assign w_j      = (i_opcode == 6'h02);
  assign w_jal    = (i_opcode == 6'h03);

  assign w_load   = w_lw || w_lb;
  assign w_store  = w_sw || w_sb;
  assign w_alu_op = w_addu || w_subu || w_slt || w_addi || w_addiu || w_ori || w_lui;
  assign w_branch = w_beq || w_bne;
  assign w_jump   = w_j || w_jal || w_jr;

  // ALU setup for EXEC; also held through ALUWB so the overflow flag that
  // ALUWB samples still belongs to this instruction.
  logic [2:0] w_op_alu_ctr;
  logic       w_op_b_sel;
  logic [1:0] w_op_ext_op;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    w_op_alu_ctr = 3'b000;
    w_op_b_sel   = 1'b0;
    w_op_ext_op  = 2'b00;
    if (w_subu)  w_op_alu_ctr = 3'b001;
    if (w_slt)   w_op_alu_ctr = 3'b100;
    if (w_addi)  begin w_op_alu_ctr = 3'b011; w_op_b_sel = 1'b1; w_op_ext_op = 2'b01; end
    if (w_addiu) begin w_op_alu_ctr = 3'b000; w_op_b_sel = 1'b1; w_op_ext_op = 2'b01; end
    if (w_ori)   begin w_op_alu_ctr = 3'b010; w_op_b_sel = 1'b1; w_op_ext_op = 2'b00; end
    if (w_lui)   begin w_op_alu_ctr = 3'b101; w_op_b_sel = 1'b1; w_op_ext_op = 2'b10; end
  end

  // Counter has reached its last allowed wait cycle.
  logic w_timeout;
  assign w_timeout = (MEM_TIMEOUT > 0) && (r_cnt == TMO_LAST);

  // ---------------- next state and outputs ----------------
  always_comb begin
    w_state_next       = r_state;
    w_cause_next       = r_cause;
    mem.imem_req       = 1'b0;
    mem.dm_req         = 1'b0;
    mem.dm_wr          = 1'b0;
    mem.word_byte_sel  = 1'b0;
    o_pc_wr            = 1'b0;
    o_npc_sel          = 3'b000;
    o_ir_wr            = 1'b0;
    o_gpr_wr           = 1'b0;
    o_alu_ctr          = 3'b000;
    o_reg_dst          = 2'b00;
    o_reg_from_sel     = 2'b00;
    o_b_sel            = 1'b0;
    o_ext_op           = 2'b00;
    o_epc_wr           = 1'b0;
    o_cause_wr         = 1'b0;
    o_exc_cause        = 2'b00;

    case (r_state)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        // Ready on the timeout cycle still counts as a normal completion.
        if (mem.imem_ready) begin
          o_ir_wr      = 1'b1;
          o_pc_wr      = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_EXC;
          w_cause_next = CAUSE_TMO;
        end
      end

      S_DECODE: begin
        if (w_load || w_store)  w_state_next = S_MADDR;
        else if (w_alu_op)      w_state_next = S_EXEC;
        else if (w_branch)      w_state_next = S_BRANCH;
        else if (w_jump)        w_state_next = S_JUMP;
        else begin
          w_state_next = S_EXC;
          w_cause_next = CAUSE_ILL;
        end
      end

      S_MADDR: begin
        o_alu_ctr    = 3'b000;
        o_b_sel      = 1'b1;
        o_ext_op     = 2'b01;
        w_state_next = w_load ? S_MRD : S_MWR;
      end

      S_MRD: begin
        mem.dm_req        = 1'b1;
        mem.word_byte_sel = w_lb;
        if (mem.dm_ready) begin
          w_state_next = S_MWB;
        end else if (w_timeout) begin
          w_state_next = S_EXC;
          w_cause_next = CAUSE_TMO;
        end
      end

      S_MWB: begin
        o_gpr_wr          = 1'b1;
        o_reg_from_sel    = 2'b01;
        o_reg_dst         = 2'b00;
        mem.word_byte_sel = w_lb;
        w_state_next      = S_FETCH;
      end

      S_MWR: begin
        mem.dm_req        = 1'b1;
        mem.dm_wr         = 1'b1;
        mem.word_byte_sel = w_sb;
        if (mem.dm_ready) begin
          w_state_next = S_FETCH;
        end else if (w_timeout) begin
          w_state_next = S_EXC;
          w_cause_next = CAUSE_TMO;
        end
      end

      S_EXEC: begin
        o_alu_ctr    = w_op_alu_ctr;
        o_b_sel      = w_op_b_sel;
        o_ext_op     = w_op_ext_op;
        w_state_next = S_ALUWB;
      end

      S_ALUWB: begin
        o_alu_ctr    = w_op_alu_ctr;
        o_b_sel      = w_op_b_sel;
        o_ext_op     = w_op_ext_op;
        o_gpr_wr     = 1'b1;
        o_reg_dst    = w_rtype ? 2'b01 : 2'b00;
        w_state_next = S_FETCH;
        if (w_addi && i_overflow) begin
          if (EXC_EN) begin
            // Suppress the write so the faulting instruction has no effect.
            o_gpr_wr     = 1'b0;
            w_state_next = S_EXC;
            w_cause_next = CAUSE_OVF;
          end else begin
            // Legacy: the overflowed result lands in $30.
            o_reg_dst = 2'b11;
          end
        end
      end

      S_BRANCH: begin
        o_alu_ctr    = 3'b001;
        o_npc_sel    = 3'b011;
        o_pc_wr      = (w_beq && i_zero) || (w_bne && !i_zero);
        w_state_next = S_FETCH;
      end

      S_JUMP: begin
        o_pc_wr   = 1'b1;
        o_npc_sel = w_jr ? 3'b010 : 3'b001;
        if (w_jal) begin
          o_gpr_wr       = 1'b1;
          o_reg_dst      = 2'b10;
          o_reg_from_sel = 2'b10;
        end
        w_state_next = S_FETCH;
      end

      S_EXC: begin
        o_epc_wr     = 1'b1;
        o_cause_wr   = 1'b1;
        o_exc_cause  = r_cause;
        o_pc_wr      = 1'b1;
        o_npc_sel    = 3'b100;
        w_state_next = S_FETCH;
      end

      default: w_state_next = S_FETCH;
    endcase
  end

  // ---------------- state, cause and wait counter ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cause <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
      // Only wait states ever stay put, and only while ready is low, so
      // "staying" means one more wait cycle; any transition restarts the
      // count for the next wait state. With the timeout disabled the
      // counter may wrap, which is harmless.
      if (w_state_next == r_state) r_cnt <= r_cnt + 1'b1;
      else                         r_cnt <= '0;
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_mc_controller_hs.sv
module tb_mc_controller_hs;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MADDR  = 4'd2;
  localparam logic [3:0] S_MRD    = 4'd3;
  localparam logic [3:0] S_MWB    = 4'd4;
  localparam logic [3:0] S_MWR    = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_EXC    = 4'd10;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, overflow, imem_ready, dm_ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] got, exp;

  always #5 clk = ~clk;

  // Main DUT: traps enabled, short timeout.
  mc_controller_hs_if mif ();
  assign mif.imem_ready = imem_ready;
  assign mif.dm_ready   = dm_ready;

  logic       pc_wr, ir_wr, gpr_wr, b_sel, epc_wr, cause_wr;
  logic [2:0] npc_sel, alu_ctr;
  logic [1:0] reg_dst, reg_from_sel, ext_op, exc_cause;
  logic [3:0] state;

  mc_controller_hs #(.MEM_TIMEOUT(4), .EXC_EN(1'b1), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .mem(mif),
    .i_opcode(opcode), .i_funct(funct), .i_zero(zero), .i_overflow(overflow),
    .o_pc_wr(pc_wr), .o_npc_sel(npc_sel), .o_ir_wr(ir_wr), .o_gpr_wr(gpr_wr),
    .o_alu_ctr(alu_ctr), .o_reg_dst(reg_dst), .o_reg_from_sel(reg_from_sel),
    .o_b_sel(b_sel), .o_ext_op(ext_op), .o_epc_wr(epc_wr), .o_cause_wr(cause_wr),
    .o_exc_cause(exc_cause), .o_state(state)
  );

  // Legacy DUT: no overflow trap, timeout disabled. Shares all inputs.
  mc_controller_hs_if lif ();
  assign lif.imem_ready = imem_ready;
  assign lif.dm_ready   = dm_ready;

  logic       l_pc_wr, l_ir_wr, l_gpr_wr, l_b_sel, l_epc_wr, l_cause_wr;
  logic [2:0] l_npc_sel, l_alu_ctr;
  logic [1:0] l_reg_dst, l_reg_from_sel, l_ext_op, l_exc_cause;
  logic [3:0] l_state;

  mc_controller_hs #(.MEM_TIMEOUT(0), .EXC_EN(1'b0), .CNT_W(5)) dut_legacy (
    .clk(clk), .rst(rst), .mem(lif),
    .i_opcode(opcode), .i_funct(funct), .i_zero(zero), .i_overflow(overflow),
    .o_pc_wr(l_pc_wr), .o_npc_sel(l_npc_sel), .o_ir_wr(l_ir_wr), .o_gpr_wr(l_gpr_wr),
    .o_alu_ctr(l_alu_ctr), .o_reg_dst(l_reg_dst), .o_reg_from_sel(l_reg_from_sel),
    .o_b_sel(l_b_sel), .o_ext_op(l_ext_op), .o_epc_wr(l_epc_wr), .o_cause_wr(l_cause_wr),
    .o_exc_cause(l_exc_cause), .o_state(l_state)
  );

  // Reset both DUTs, ending at a falling edge in FETCH with all inputs idle.
  task automatic do_reset();
    opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
    imem_ready = 1'b0; dm_ready = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    // Every output: state, imem_req, dm_req, dm_wr, pc_wr, npc_sel, ir_wr,
    // gpr_wr, alu_ctr, reg_dst, reg_from_sel, b_sel, ext_op, wbs, epc_wr,
    // cause_wr, exc_cause. Only imem_req may be high.
    got = {state, mif.imem_req, mif.dm_req, mif.dm_wr, pc_wr, npc_sel, ir_wr,
           gpr_wr, alu_ctr, reg_dst, reg_from_sel, b_sel, ext_op,
           mif.word_byte_sel, epc_wr, cause_wr, exc_cause};
    exp = {4'd0, 1'b1, 23'd0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_idle got %h want %h", got, exp); end

    // Reset asserted mid-store must drop the request in the same cycle.
    opcode = 6'h2b; imem_ready = 1'b1; dm_ready = 1'b0;
    step(); step(); step();
    got = {state, mif.dm_req, mif.dm_wr};
    exp = {S_MWR, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_pre_mwr got %h want %h", got, exp); end
    #2 rst = 1'b1;
    #1;
    got = {state, mif.dm_req, mif.dm_wr};
    exp = {S_FETCH, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_mid_mwr got %h want %h", got, exp); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_addu();
    do_reset();
    opcode = 6'h00; funct = 6'h21; imem_ready = 1'b1; dm_ready = 1'b1;
    #1;
    got = {state, mif.imem_req, ir_wr, pc_wr, npc_sel, gpr_wr};
    exp = {S_FETCH, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL addu_c1 got %h want %h", got, exp); end
    step();
    got = {state, pc_wr, gpr_wr, ir_wr};
    exp = {S_DECODE, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL addu_c2 got %h want %h", got, exp); end
    step();
    got = {state, pc_wr, gpr_wr, alu_ctr, b_sel};
    exp = {S_EXEC, 1'b0, 1'b0, 3'b000, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL addu_c3 got %h want %h", got, exp); end
    step();
    got = {state, pc_wr, gpr_wr, reg_dst, reg_from_sel};
    exp = {S_ALUWB, 1'b0, 1'b1, 2'b01, 2'b00};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL addu_c4 got %h want %h", got, exp); end
    // Back-to-back: the next fetch completes immediately.
    step();
    got = {state, pc_wr, ir_wr};
    exp = {S_FETCH, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL addu_next_fetch got %h want %h", got, exp); end
  endtask

  task automatic test_alu_ops();
    logic [5:0] op  [7] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0d, 6'h0f};
    logic [5:0] fn  [7] = '{6'h21, 6'h23, 6'h2a, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [2:0] alu [7] = '{3'b000, 3'b001, 3'b100, 3'b011, 3'b000, 3'b010, 3'b101};
    logic       bs  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] ex  [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    logic [1:0] rd  [7] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      opcode = op[i]; funct = fn[i]; imem_ready = 1'b1;
      step(); step();
      got = {state, alu_ctr, b_sel, ext_op};
      exp = {S_EXEC, alu[i], bs[i], ex[i]};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL alu_exec[%0d] got %h want %h", i, got, exp); end
      step();
      got = {state, gpr_wr, reg_dst};
      exp = {S_ALUWB, 1'b1, rd[i]};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL alu_wb[%0d] got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_lw_wait();
    do_reset();
    opcode = 6'h23; imem_ready = 1'b1; dm_ready = 1'b0;
    step(); step();
    got = {state, alu_ctr, b_sel, ext_op};
    exp = {S_MADDR, 3'b000, 1'b1, 2'b01};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lw_maddr got %h want %h", got, exp); end
    // Four MRD cycles; ready arrives on the 4th, which is also the last
    // allowed wait cycle with MEM_TIMEOUT=4, so completion must win.
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 3) begin dm_ready = 1'b1; #1; end
      got = {state, mif.dm_req, mif.dm_wr, gpr_wr};
      exp = {S_MRD, 1'b1, 1'b0, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL lw_mrd[%0d] got %h want %h", c, got, exp); end
    end
    step();
    got = {state, gpr_wr, reg_from_sel, reg_dst, mif.word_byte_sel, mif.dm_req};
    exp = {S_MWB, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lw_mwb got %h want %h", got, exp); end
    step();
    got = {28'd0, state};
    exp = {28'd0, S_FETCH};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lw_done got %h want %h", got, exp); end
  endtask

  task automatic test_byte();
    do_reset();
    opcode = 6'h28; imem_ready = 1'b1; dm_ready = 1'b1;
    step(); step(); step();
    got = {state, mif.dm_req, mif.dm_wr, mif.word_byte_sel};
    exp = {S_MWR, 1'b1, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sb_mwr got %h want %h", got, exp); end
    do_reset();
    opcode = 6'h20; imem_ready = 1'b1; dm_ready = 1'b1;
    step(); step(); step(); step();
    got = {state, gpr_wr, mif.word_byte_sel};
    exp = {S_MWB, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lb_mwb got %h want %h", got, exp); end
  endtask

  task automatic test_branch();
    logic [5:0] op [4] = '{6'h05, 6'h05, 6'h04, 6'h04};
    logic       zf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      opcode = op[i]; zero = zf[i]; imem_ready = 1'b1;
      step(); step();
      got = {state, pc_wr, npc_sel, alu_ctr, gpr_wr};
      exp = {S_BRANCH, tk[i], 3'b011, 3'b001, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL branch[%0d] got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_jump();
    logic [5:0] op [3] = '{6'h02, 6'h03, 6'h00};
    logic [5:0] fn [3] = '{6'h00, 6'h00, 6'h08};
    logic [2:0] ns [3] = '{3'b001, 3'b001, 3'b010};
    logic       gw [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] rd [3] = '{2'b00, 2'b10, 2'b00};
    logic [1:0] rf [3] = '{2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      opcode = op[i]; funct = fn[i]; imem_ready = 1'b1;
      step(); step();
      got = {state, pc_wr, npc_sel, gpr_wr, reg_dst, reg_from_sel};
      exp = {S_JUMP, 1'b1, ns[i], gw[i], rd[i], rf[i]};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL jump[%0d] got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    opcode = 6'h08; imem_ready = 1'b1; overflow = 1'b1;
    step(); step();
    step();
    got = {state, gpr_wr, l_state, l_gpr_wr, l_reg_dst};
    exp = {S_ALUWB, 1'b0, S_ALUWB, 1'b1, 2'b11};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ovf_aluwb got %h want %h", got, exp); end
    step();
    got = {state, gpr_wr, epc_wr, cause_wr, exc_cause, pc_wr, npc_sel, l_state};
    exp = {S_EXC, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 3'b100, S_FETCH};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ovf_exc got %h want %h", got, exp); end
    step();
    got = {state, epc_wr, cause_wr};
    exp = {S_FETCH, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ovf_after got %h want %h", got, exp); end
  endtask

  task automatic test_timeout();
    do_reset();
    #1;
    for (int c = 0; c < 4; c++) begin
      got = {state, mif.imem_req, ir_wr, pc_wr};
      exp = {S_FETCH, 1'b1, 1'b0, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL tmo_fetch[%0d] got %h want %h", c, got, exp); end
      step();
    end
    got = {state, epc_wr, cause_wr, exc_cause, npc_sel, mif.imem_req, l_state};
    exp = {S_EXC, 1'b1, 1'b1, 2'b11, 3'b100, 1'b0, S_FETCH};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL tmo_exc got %h want %h", got, exp); end

    // Data-read timeout: no writeback may happen.
    do_reset();
    opcode = 6'h23; imem_ready = 1'b1; dm_ready = 1'b0;
    for (int c = 0; c < 7; c++) step();
    got = {state, gpr_wr, exc_cause, cause_wr};
    exp = {S_EXC, 1'b0, 2'b11, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL tmo_mrd got %h want %h", got, exp); end
  endtask

  task automatic test_illegal();
    logic [5:0] op [2] = '{6'h3f, 6'h00};
    logic [5:0] fn [2] = '{6'h00, 6'h00};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      opcode = op[i]; funct = fn[i]; imem_ready = 1'b1;
      step();
      got = {28'd0, state};
      exp = {28'd0, S_DECODE};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL ill_decode[%0d] got %h want %h", i, got, exp); end
      step();
      got = {state, epc_wr, cause_wr, exc_cause, pc_wr, npc_sel};
      exp = {S_EXC, 1'b1, 1'b1, 2'b10, 1'b1, 3'b100};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL ill_exc[%0d] got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_addu();
    test_alu_ops();
    test_lw_wait();
    test_byte();
    test_branch();
    test_jump();
    test_overflow();
    test_timeout();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
